overlay_mixer: RTL and testbench

//  Pixel-path stage directly downstream of emblem_gen. Takes emblem_gen's draw/rgb
//  and a background colour, and alpha-blends the overlay onto the background.

---
 rtl/overlay_pkg.sv | 11 +
 rtl/rgb222_blend.sv | 20 ++
 rtl/overlay_mixer.sv | 100 ++++++++++
 tb/tb_overlay_mixer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/overlay_pkg.sv
// overlay_pkg: shared state type, widths and colour constants for the overlay pixel path
package overlay_pkg;
    typedef enum logic [1:0] {HIDDEN, FADE_IN, SHOWN, FADE_OUT} fade_state_t;
    localparam int CH_W = 2;
    localparam int LVL_W = 3;
    localparam int RGB_W = 3 * CH_W;
    localparam int BLEND_SH = 2;
    localparam logic [RGB_W-1:0] COLOR_BLACK = 6'b000000;
    localparam logic [RGB_W-1:0] COLOR_GOLD = 6'b111100;
    localparam logic [RGB_W-1:0] COLOR_RED = 6'b110000;
endpackage

// File: rtl/rgb222_blend.sv
// rgb222_blend: per-channel alpha blend of overlay onto background, opacity lvl out of 4
module rgb222_blend
    import overlay_pkg::*;
(
    input  logic [RGB_W-1:0] ov_i,
    input  logic [RGB_W-1:0] bg_i,
    input  logic             draw_i,
    input  logic [LVL_W-1:0] lvl_i,
    output logic [RGB_W-1:0] rgb_o
);
    localparam logic [LVL_W-1:0] FULL = LVL_W'(1 << BLEND_SH);

    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [3:0] mix;
        // worst case 3*4 = 12, so the 4-bit sum never overflows
        assign mix = 4'(ov_i[CH_W*c +: CH_W]) * 4'(lvl_i)
                   + 4'(bg_i[CH_W*c +: CH_W]) * 4'(FULL - lvl_i);
        assign rgb_o[CH_W*c +: CH_W] = draw_i ? CH_W'(mix >> BLEND_SH) : bg_i[CH_W*c +: CH_W];
    end
endmodule

// File: rtl/overlay_mixer.sv
// overlay_mixer: 2-stage blend of emblem overlay onto background with a
// frame-synchronous fade in/out controller driving the blend strength
module overlay_mixer
    import overlay_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 8,
    parameter int MAX_LEVEL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             active_in,
    input  logic             ov_draw,
    input  logic [RGB_W-1:0] ov_rgb,
    input  logic [RGB_W-1:0] bg_rgb,
    input  logic             show,
    output logic             hsync,
    output logic             vsync,
    output logic [RGB_W-1:0] rgb,
    output logic [LVL_W-1:0] fade_level,
    output logic             fading
);
    localparam logic [7:0] CNT_LAST = 8'(FRAMES_PER_STEP - 1);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(MAX_LEVEL);

    fade_state_t state_q, state_d;
    logic [LVL_W-1:0] lvl_q, lvl_d, lvl_up, lvl_dn, s1_lvl_q;
    logic [7:0] cnt_q, cnt_d;
    logic s1_hs_q, s1_vs_q, s1_act_q, s1_draw_q, hs_q, vs_q, vs_prev_q, tick, step;
    logic [RGB_W-1:0] s1_ov_q, s1_bg_q, rgb_q, blend_rgb;

    rgb222_blend u_blend (
        .ov_i  (s1_ov_q),
        .bg_i  (s1_bg_q),
        .draw_i(s1_draw_q),
        .lvl_i (s1_lvl_q),
        .rgb_o (blend_rgb)
    );

    assign tick = vsync_in && !vs_prev_q;
    assign step = tick && cnt_q == CNT_LAST;
    assign lvl_up = lvl_q == LVL_MAX ? lvl_q : lvl_q + LVL_W'(1);
    assign lvl_dn = lvl_q == '0 ? lvl_q : lvl_q - LVL_W'(1);

    always_comb begin
        state_d = state_q;
        lvl_d = lvl_q;
        cnt_d = cnt_q;
        case (state_q)
            HIDDEN: state_d = show ? FADE_IN : HIDDEN;
            FADE_IN: begin
                if (!show) state_d = FADE_OUT;
                else if (tick) begin
                    cnt_d = step ? '0 : cnt_q + 8'd1;
                    lvl_d = step ? lvl_up : lvl_q;
                    state_d = step && lvl_up == LVL_MAX ? SHOWN : FADE_IN;
                end
            end
            SHOWN: state_d = show ? SHOWN : FADE_OUT;
            FADE_OUT: begin
                if (show) state_d = FADE_IN;
                else if (tick) begin
                    cnt_d = step ? '0 : cnt_q + 8'd1;
                    lvl_d = step ? lvl_dn : lvl_q;
                    state_d = step && lvl_dn == '0 ? HIDDEN : FADE_OUT;
                end
            end
            default: state_d = HIDDEN;
        endcase
        // every state change restarts the frame count; show-driven changes also swallow a coincident step
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {s1_hs_q, s1_vs_q, s1_act_q, s1_draw_q, hs_q, vs_q} <= '0;
            {s1_ov_q, s1_bg_q, rgb_q, s1_lvl_q} <= '0;
            vs_prev_q <= 1'b1;
            state_q <= HIDDEN;
            lvl_q <= '0;
            cnt_q <= '0;
        end else begin
            {s1_hs_q, s1_vs_q, s1_act_q, s1_draw_q} <= {hsync_in, vsync_in, active_in, ov_draw};
            {s1_ov_q, s1_bg_q, s1_lvl_q} <= {ov_rgb, bg_rgb, lvl_q};
            {hs_q, vs_q} <= {s1_hs_q, s1_vs_q};
            rgb_q <= s1_act_q ? blend_rgb : COLOR_BLACK;
            vs_prev_q <= vsync_in;
            state_q <= state_d;
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
        end
    end

    assign hsync = hs_q;
    assign vsync = vs_q;
    assign rgb = rgb_q;
    assign fade_level = lvl_q;
    assign fading = state_q == FADE_IN || state_q == FADE_OUT;
endmodule

// File: tb/tb_overlay_mixer.sv
// tb_overlay_mixer: randomized checks of overlay_mixer against a frame/level reference model
module tb_overlay_mixer;
    localparam int FPS = 2;
    logic clk = 1'b0, rst_n = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic active_in = 1'b0, ov_draw = 1'b0, show = 1'b0;
    logic [5:0] ov_rgb = '0, bg_rgb = '0;
    logic hsync, vsync, fading;
    logic [5:0] rgb;
    logic [2:0] fade_level;
    int n_cmp = 0, n_bad = 0, fpos = 0, rises = 0;
    int m_lvl = 0, m_dir = 0, m_ticks = 0;
    bit m_vprev = 1'b1, vs_last = 1'b0;
    logic [5:0] e_s1_rgb = '0, e_rgb = '0;
    bit e_s1_h, e_s1_v, e_h, e_v;

    overlay_mixer #(.FRAMES_PER_STEP(FPS), .MAX_LEVEL(4)) dut (
        .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .active_in(active_in), .ov_draw(ov_draw), .ov_rgb(ov_rgb), .bg_rgb(bg_rgb),
        .show(show), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .fade_level(fade_level), .fading(fading)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] pix(bit act, bit draw, logic [5:0] ov, logic [5:0] bg, int l);
        logic [5:0] r;
        if (!act) return 6'b0;
        if (!draw) return bg;
        for (int c = 0; c < 3; c++) r[2*c +: 2] = 2'((int'(ov[2*c +: 2]) * l + int'(bg[2*c +: 2]) * (4 - l)) / 4);
        return r;
    endfunction

    function automatic logic [11:0] exp_vec();
        return {e_h, e_v, e_rgb, 3'(m_lvl), m_dir != 0};
    endfunction

    function automatic logic [11:0] act_vec();
        return {hsync, vsync, rgb, fade_level, fading};
    endfunction

    // Level model: direction follows show, level moves one unit every FPS frame ticks
    task automatic model_edge();
        bit tick;
        int want, goal;
        if (!rst_n) begin
            m_lvl = 0; m_dir = 0; m_ticks = 0; m_vprev = 1'b1;
            e_s1_rgb = '0; e_rgb = '0; {e_s1_h, e_s1_v, e_h, e_v} = '0;
            return;
        end
        {e_rgb, e_h, e_v} = {e_s1_rgb, e_s1_h, e_s1_v};
        e_s1_rgb = pix(active_in, ov_draw, ov_rgb, bg_rgb, m_lvl);
        {e_s1_h, e_s1_v} = {hsync_in, vsync_in};
        tick = vsync_in && !m_vprev;
        m_vprev = vsync_in;
        want = show ? 1 : -1;
        goal = show ? 4 : 0;
        if (m_dir != want && !(m_dir == 0 && m_lvl == goal)) begin
            m_dir = want;
            m_ticks = 0;
        end else if (m_dir != 0 && tick) begin
            m_ticks++;
            if (m_ticks == FPS) begin
                m_ticks = 0;
                m_lvl = m_lvl + m_dir;
                if (m_lvl > 4) m_lvl = 4;
                if (m_lvl < 0) m_lvl = 0;
                if (m_lvl == goal) m_dir = 0;
            end
        end
    endtask

    // vs_mode: 0 low, 1 high, 2 free-running 6-cycle frame with 2-cycle vsync
    task automatic step(int vs_mode, bit rnd);
        if (rnd) {hsync_in, active_in, ov_draw, ov_rgb, bg_rgb} = 15'($urandom);
        vsync_in = vs_mode == 2 ? (fpos % 6 >= 4) : vs_mode[0];
        fpos++;
        if (rst_n && vsync_in && !vs_last) rises++;
        vs_last = vsync_in;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; show = 1'b0;
        repeat (3) step(2, 1);
        if (act_vec() !== 12'h0) begin n_bad++; $display("FAIL reset_outputs: got %h expected 000", act_vec()); end
        n_cmp++;
        rst_n = 1'b1;
        repeat (30) begin
            step(2, 1);
            if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL reset_sync_track: got %h expected %h", act_vec(), exp_vec()); end
            n_cmp++;
        end
    endtask

    task automatic test_blend_lvl0();
        {bg_rgb, ov_rgb, ov_draw, active_in, hsync_in} = {6'b000011, 6'b110110, 3'b110};
        repeat (2) step(0, 0);
        if (rgb !== 6'b000011) begin n_bad++; $display("FAIL blend_lvl0: got %b expected 000011", rgb); end
        if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL blend_lvl0_model: got %h expected %h", act_vec(), exp_vec()); end
        n_cmp += 2;
    endtask

    task automatic test_fade_in();
        show = 1'b1;
        step(0, 1);
        rises = 0;
        for (int i = 0; i < 300 && fade_level != 3'd2; i++) begin
            step(2, 1);
            if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL fade_in_to2: got %h expected %h", act_vec(), exp_vec()); end
            n_cmp++;
        end
        if (fade_level !== 3'd2) begin n_bad++; $display("FAIL fade_in_reach2: got %0d expected 2", fade_level); end
        n_cmp++;
        {bg_rgb, ov_rgb, ov_draw, active_in} = {6'b000011, 6'b110110, 2'b11};
        repeat (2) step(0, 0);
        if (rgb !== 6'b010010) begin n_bad++; $display("FAIL blend_lvl2: got %b expected 010010", rgb); end
        n_cmp++;
        for (int i = 0; i < 300 && fade_level != 3'd4; i++) begin
            step(2, 1);
            if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL fade_in_to4: got %h expected %h", act_vec(), exp_vec()); end
            n_cmp++;
        end
        if ({fade_level, fading} !== {3'd4, 1'b0}) begin n_bad++; $display("FAIL shown_state: got lvl %0d fading %b expected 4/0", fade_level, fading); end
        if (rises !== 4 * FPS) begin n_bad++; $display("FAIL fade_in_ticks: got %0d expected %0d", rises, 4 * FPS); end
        n_cmp += 2;
        {bg_rgb, ov_rgb, ov_draw, active_in} = {6'b000011, 6'b110110, 2'b11};
        repeat (2) step(0, 0);
        if (rgb !== 6'b110110) begin n_bad++; $display("FAIL blend_lvl4: got %b expected 110110", rgb); end
        n_cmp++;
    endtask

    task automatic test_fade_out_mid();
        int maxl;
        rst_n = 1'b0;
        step(0, 1);
        rst_n = 1'b1; show = 1'b1;
        step(0, 1);
        for (int i = 0; i < 300 && fade_level != 3'd2; i++) begin
            step(2, 1);
            if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL fade_mid_up: got %h expected %h", act_vec(), exp_vec()); end
            n_cmp++;
        end
        show = 1'b0;
        step(0, 1);
        if ({fade_level, fading} !== {3'd2, 1'b1}) begin n_bad++; $display("FAIL fade_out_start: got lvl %0d fading %b expected 2/1", fade_level, fading); end
        n_cmp++;
        rises = 0; maxl = 0;
        for (int i = 0; i < 300 && fade_level != 3'd0; i++) begin
            step(2, 1);
            if (int'(fade_level) > maxl) maxl = int'(fade_level);
            if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL fade_out_run: got %h expected %h", act_vec(), exp_vec()); end
            n_cmp++;
        end
        if ({fade_level, fading} !== {3'd0, 1'b0}) begin n_bad++; $display("FAIL hidden_state: got lvl %0d fading %b expected 0/0", fade_level, fading); end
        if (rises !== 2 * FPS) begin n_bad++; $display("FAIL fade_out_ticks: got %0d expected %0d", rises, 2 * FPS); end
        if (maxl !== 2) begin n_bad++; $display("FAIL fade_out_nojump: got max %0d expected 2", maxl); end
        n_cmp += 3;
    endtask

    task automatic test_active();
        show = 1'b1;
        for (int i = 0; i < 300 && fade_level != 3'd1; i++) step(2, 1);
        if (fade_level !== 3'd1) begin n_bad++; $display("FAIL active_setup: got %0d expected 1", fade_level); end
        n_cmp++;
        repeat (4) begin
            ov_rgb = 6'($urandom_range(1, 63)); bg_rgb = 6'($urandom_range(1, 63));
            {ov_draw, active_in} = 2'b10;
            repeat (2) step(0, 0);
            if (rgb !== 6'b0) begin n_bad++; $display("FAIL inactive_black: got %b expected 000000", rgb); end
            {ov_draw, active_in} = 2'b01;
            repeat (2) step(0, 0);
            if (rgb !== bg_rgb) begin n_bad++; $display("FAIL nodraw_bg: got %b expected %b", rgb, bg_rgb); end
            if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL active_model: got %h expected %h", act_vec(), exp_vec()); end
            n_cmp += 3;
        end
    endtask

    task automatic test_reset_mid();
        hsync_in = 1'b1;
        rst_n = 1'b0;
        step(1, 1);
        if (act_vec() !== 12'h0) begin n_bad++; $display("FAIL midreset_outputs: got %h expected 000", act_vec()); end
        n_cmp++;
        step(1, 1);
        rst_n = 1'b1; show = 1'b1;
        repeat (4) begin
            step(1, 1);
            if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL midreset_held: got %h expected %h", act_vec(), exp_vec()); end
            n_cmp++;
        end
        repeat (2) step(0, 1);
        repeat (2) step(1, 1);
        if (fade_level !== 3'd0) begin n_bad++; $display("FAIL held_vsync_notick: got %0d expected 0", fade_level); end
        n_cmp++;
        repeat (2) step(0, 1);
        step(1, 1);
        if (fade_level !== 3'd1) begin n_bad++; $display("FAIL fresh_tick_step: got %0d expected 1", fade_level); end
        if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL midreset_model: got %h expected %h", act_vec(), exp_vec()); end
        n_cmp += 2;
    endtask

    task automatic test_random();
        repeat (400) begin
            if ($urandom_range(0, 29) == 0) show = ~show;
            step(2, 1);
            if (act_vec() !== exp_vec()) begin n_bad++; $display("FAIL random_soak: got %h expected %h", act_vec(), exp_vec()); end
            n_cmp++;
        end
    endtask

    initial begin
        test_reset();
        test_blend_lvl0();
        test_fade_in();
        test_fade_out_mid();
        test_active();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
